// File: rtl/sdp_ram_be_pipe.sv
// sdp_ram_be_pipe: simple dual-port byte-enable RAM with pipelined reads and a zero-fill sequencer
module sdp_ram_be_pipe #(
  parameter int    AW            = 4,
  parameter int    DW            = 16,
  parameter int    RD_LAT        = 1,
  parameter string RDW_MODE      = "READ_FIRST",
  parameter bit    CLR_ON_RST    = 1'b1,
  parameter string RAM_STYLE_VAL = "block"
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wen,
  input  logic [DW/8-1:0] wbe,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   din,
  input  logic            ren,
  input  logic [AW-1:0]   raddr,
  input  logic            clr,
  output logic [DW-1:0]   dout,
  output logic            dout_vld,
  output logic            busy
);
  localparam int DEPTH = 2**AW;
  localparam int NB = DW/8;
  if (DW % 8 != 0 || RD_LAT < 1 || RD_LAT > 3 || RAM_STYLE_VAL == "" ||
      (RDW_MODE != "READ_FIRST" && RDW_MODE != "WRITE_FIRST")) begin : g_bad_param
    $error("sdp_ram_be_pipe: illegal parameter value");
  end
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic wr_acc, rd_acc;
  logic [DW-1:0] rd_data;
  logic [RD_LAT-1:0] pv_q;
  logic [DW-1:0] pd_q [RD_LAT];
  (* ram_style = RAM_STYLE_VAL *) logic [DW-1:0] mem_q [DEPTH];
  assign busy = state_q == CLEAR;
  assign wr_acc = rst_n && !busy && !clr && wen;
  assign rd_acc = rst_n && !busy && !clr && ren;
  assign dout = pd_q[RD_LAT-1];
  assign dout_vld = pv_q[RD_LAT-1];
  always_comb begin
    state_d = busy ? (cnt_q == AW'(DEPTH-1) ? READY : CLEAR) : (clr ? CLEAR : READY);
    cnt_d = busy ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= CLR_ON_RST ? CLEAR : READY;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // array is never reset; only the fill sequencer zeroes it
  always_ff @(posedge clk)
    if (rst_n && busy) mem_q[cnt_q] <= '0;
    else if (wr_acc)
      for (int i = 0; i < NB; i++)
        if (wbe[i]) mem_q[waddr][8*i +: 8] <= din[8*i +: 8];
  always_comb begin
    rd_data = mem_q[raddr];
    for (int i = 0; i < NB; i++)
      if (RDW_MODE == "WRITE_FIRST" && wr_acc && waddr == raddr && wbe[i])
        rd_data[8*i +: 8] = din[8*i +: 8];
  end
  // data stages only load behind a valid, so dout holds between reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv_q <= '0;
      for (int k = 0; k < RD_LAT; k++) pd_q[k] <= '0;
    end else begin
      pv_q[0] <= rd_acc;
      if (rd_acc) pd_q[0] <= rd_data;
      for (int k = 1; k < RD_LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
        if (pv_q[k-1]) pd_q[k] <= pd_q[k-1];
      end
    end
endmodule

// File: doc/sdp_ram_be_pipe.md
SDP_RAM_BE_PIPE -- requirements
Module: sdp_ram_be_pipe

Interface
REQ-001 The block SHALL have parameter AW, default 4, meaning address width; DEPTH = 2**AW.
REQ-002 The block SHALL have parameter DW, default 16, meaning data width; it must be a multiple of 8; NB = DW/8 byte lanes.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning read latency in cycles; legal range 1..3.
REQ-004 The block SHALL have parameter RDW_MODE, default "READ_FIRST", meaning same-address read/write policy; legal values "READ_FIRST" and "WRITE_FIRST".
REQ-005 The block SHALL have parameter CLR_ON_RST, default 1, meaning that 1 zero-fills the array after reset.
REQ-006 The block SHALL have parameter RAM_STYLE_VAL, default "block", meaning the synthesis attribute on the array.
REQ-007 The block SHALL have port clk, input, width 1, meaning the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst_n, input, width 1, meaning an asynchronous, active-low reset.
REQ-009 The block SHALL have port wen, input, width 1, meaning write request.
REQ-010 The block SHALL have port wbe, input, width NB, meaning byte write enables; bit i covers din[8i+7:8i].
REQ-011 The block SHALL have port waddr, input, width AW, meaning write address.
REQ-012 The block SHALL have port din, input, width DW, meaning write data.
REQ-013 The block SHALL have port ren, input, width 1, meaning read request.
REQ-014 The block SHALL have port raddr, input, width AW, meaning read address.
REQ-015 The block SHALL have port clr, input, width 1, meaning a one-cycle pulse that requests a full zero-fill.
REQ-016 The block SHALL have port dout, output, width DW, meaning read data.
REQ-017 The block SHALL have port dout_vld, output, width 1, meaning dout holds the result of a read this cycle.
REQ-018 The block SHALL have port busy, output, width 1, meaning a zero-fill is in progress and requests are ignored.

Function
REQ-019 Control SHALL be an FSM with two states, CLEAR and READY; busy = (state == CLEAR).
REQ-020 In CLEAR, the block SHALL write all-zero to address clr_cnt each cycle, with clr_cnt counting 0 up to DEPTH-1.
REQ-021 On the cycle clr_cnt = DEPTH-1, the FSM SHALL go to READY; busy is high for exactly DEPTH cycles.
REQ-022 In READY, clr=1 SHALL move the FSM to CLEAR with clr_cnt = 0, and wen/ren sampled on that same edge SHALL be ignored.
REQ-023 In CLEAR, clr, wen and ren SHALL be ignored; ignored reads produce no dout_vld.
REQ-024 In READY, on an edge with wen=1, the block SHALL write only those byte lanes of mem[waddr] whose wbe bit is 1; wbe = 0 leaves the word unchanged.
REQ-025 In READY, a read with ren=1 sampled at edge N SHALL drive dout and dout_vld=1 for the cycle after edge N+RD_LAT-1, i.e. exactly one cycle per read.
REQ-026 Back-to-back reads SHALL be fully pipelined at one per cycle with no bubbles.
REQ-027 dout SHALL hold its last value while dout_vld=0.
REQ-028 A write at edge N SHALL be visible to any read sampled at edge N+1 or later.
REQ-029 Collision case (ren and wen on the same edge with raddr == waddr) in READ_FIRST mode SHALL return the word as it was before the write.
REQ-030 Collision case in WRITE_FIRST mode SHALL return the byte-merged result: din on enabled lanes, old data on the rest.
REQ-031 A read in flight when clr is accepted SHALL still complete with its pre-clear data and dout_vld.

Reset
REQ-032 While rst_n=0 (asynchronous), the block SHALL hold dout=0 and dout_vld=0, and flush all read-pipeline valid bits.
REQ-033 While rst_n=0, the block SHALL set clr_cnt=0 and set state to CLEAR if CLR_ON_RST=1, else READY; busy follows state.
REQ-034 Array contents SHALL NOT be reset by rst_n; only CLEAR zeroes them.
REQ-035 Reset asserted mid-CLEAR SHALL restart the fill from address 0 after deassertion.

Verification
REQ-036 The bench SHALL check reset fill: AW=4, CLR_ON_RST=1, release rst_n -> busy=1 for 16 cycles, then 0; reading all 16 addresses returns 0x0000.
REQ-037 The bench SHALL check byte enables: write 0xABCD to addr 3 with wbe=11, then 0x1200 with wbe=10; read addr 3 -> 0x12CD.
REQ-038 The bench SHALL check collision: mem[5]=0x1111; same edge wen with 0x2222, wbe=11, ren, both at addr 5 -> READ_FIRST returns 0x1111, WRITE_FIRST returns 0x2222.
REQ-039 The bench SHALL check latency: RD_LAT=3, ren on 4 consecutive edges at addr 0..3 -> dout_vld high for 4 consecutive cycles starting 3 cycles after the first edge, with data in order.
REQ-040 The bench SHALL check clr and requests: pulse clr in READY with wen on the same edge -> the write is dropped and busy=1 for 16 cycles; wen/ren during busy have no effect and give no dout_vld.
REQ-041 The bench SHALL check reset mid-fill: assert rst_n=0 at clr_cnt=7 -> dout_vld=0 immediately; after release, busy lasts a full 16 cycles.
